bram_porta_arbiter: RTL and testbench

BRAM_PORTA_ARBITER -- requirements
Module: bram_porta_arbiter

---
 rtl/bram_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 33 +++
 rtl/bram_porta_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_porta_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port-A arbiter: FSM state encoding and grant constants.
package bram_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_R0   = 2'b01;
  localparam logic [1:0] GRANT_R1   = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a sole requester always wins, a tie goes to the
// requester not granted last. The pointer moves only when advance_i is high.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
  logic last_q, last_d;

  always_comb begin
    grant_o = GRANT_NONE;
    case (valid_i)
      2'b01:   grant_o = GRANT_R0;
      2'b10:   grant_o = GRANT_R1;
      2'b11:   grant_o = last_q ? GRANT_R0 : GRANT_R1;
      default: grant_o = GRANT_NONE;
    endcase
    last_d = last_q;
    if (advance_i && (grant_o != GRANT_NONE)) last_d = grant_o[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/bram_porta_arbiter.sv
// Arbitrates two requesters onto BRAM port A and owns a fill engine that writes
// one value to every word, locking out requesters while it runs.
module bram_porta_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 2,
  parameter int DEPTH_WORDS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          r0_valid_i,
  output logic                          r0_ready_o,
  input  logic                          r0_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0]         r0_wdata_i,
  output logic                          r0_rvalid_o,
  output logic [DATA_WIDTH-1:0]         r0_rdata_o,
  input  logic                          r1_valid_i,
  output logic                          r1_ready_o,
  input  logic                          r1_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0]         r1_wdata_i,
  output logic                          r1_rvalid_o,
  output logic [DATA_WIDTH-1:0]         r1_rdata_o,
  input  logic                          fill_start_i,
  input  logic [DATA_WIDTH-1:0]         fill_data_i,
  output logic                          fill_busy_o,
  output logic                          fill_done_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] bram_addr_o,
  output logic                          bram_we_o,
  output logic [DATA_WIDTH-1:0]         bram_din_o,
  input  logic [DATA_WIDTH-1:0]         bram_dout_i,
  output arb_state_e                    dbg_state_o
);

  localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_WORDS - 1);

  // Handshake: a transfer on requester n happens on a rising edge where
  // rn_valid_i && rn_ready_o; ready is combinational and one-hot-or-zero.

  arb_state_e             state_q;
  logic [ADDR_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0]  fill_val_q;
  logic                   done_q;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0]             grant;
  logic                   idle;

  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   ({r1_valid_i, r0_valid_i} & {2{idle}}),
    .advance_i (idle),
    .grant_o   (grant)
  );

  assign r0_ready_o = grant[0];
  assign r1_ready_o = grant[1];

  always_comb begin
    bram_we_o   = 1'b0;
    bram_addr_o = '0;
    bram_din_o  = '0;
    if (!idle) begin
      bram_we_o   = 1'b1;
      bram_addr_o = cnt_q;
      bram_din_o  = fill_val_q;
    end else if (grant[0]) begin
      bram_we_o   = r0_we_i;
      bram_addr_o = r0_addr_i;
      bram_din_o  = r0_wdata_i;
    end else if (grant[1]) begin
      bram_we_o   = r1_we_i;
      bram_addr_o = r1_addr_i;
      bram_din_o  = r1_wdata_i;
    end
  end

  // Read data lands one cycle after acceptance, in step with the BRAM's output register
  assign rvalid_d = {grant[1] & ~r1_we_i, grant[0] & ~r0_we_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      done_q     <= 1'b0;
      rvalid_q   <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fill_start_i) begin
            state_q    <= ST_FILL;
            fill_val_q <= fill_data_i;
            cnt_q      <= '0;
          end
        end
        ST_FILL: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign r0_rvalid_o = rvalid_q[0];
  assign r1_rvalid_o = rvalid_q[1];
  assign r0_rdata_o  = bram_dout_i;
  assign r1_rdata_o  = bram_dout_i;
  assign fill_busy_o = ~idle;
  assign fill_done_o = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_porta_arbiter.sv
// Bench for bram_porta_arbiter: a 16-word DUT on a behavioural BRAM for the main
// scenarios and a 10-word DUT for the non-power-of-two fill.
module tb_bram_porta_arbiter;
  import bram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT16 signals + BRAM model ----------------
  logic          r0_valid, r0_we, r1_valid, r1_we, fill_start;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, fill_data;
  logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid, fill_busy, fill_done;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_din, bram_dout;
  arb_state_e    dbg16;
  logic [DW-1:0] mem16 [16];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem16[i] <= '0;
    end else begin
      if (bram_we) mem16[bram_addr] <= bram_din;
      bram_dout <= mem16[bram_addr];
    end
  end

  bram_porta_arbiter #(.DATA_WIDTH(DW), .DEPTH_WORDS(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
    .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
    .fill_start_i(fill_start), .fill_data_i(fill_data),
    .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .bram_addr_o(bram_addr), .bram_we_o(bram_we), .bram_din_o(bram_din),
    .bram_dout_i(bram_dout), .dbg_state_o(dbg16)
  );

  // ---------------- DUT10 signals + BRAM model ----------------
  logic          z_bit;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_data;
  logic          f10_start;
  logic [DW-1:0] f10_data;
  logic          r0_ready10, r1_ready10, r0_rvalid10, r1_rvalid10, busy10, done10;
  logic [DW-1:0] r0_rdata10, r1_rdata10;
  logic [AW-1:0] addr10;
  logic          we10;
  logic [DW-1:0] din10, dout10;
  arb_state_e    dbg10;
  logic [DW-1:0] mem10 [16];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem10[i] <= '0;
    end else begin
      if (we10) mem10[addr10] <= din10;
      dout10 <= mem10[addr10];
    end
  end

  bram_porta_arbiter #(.DATA_WIDTH(DW), .DEPTH_WORDS(10)) u_dut10 (
    .clk_i(clk), .rst_i(rst),
    .r0_valid_i(z_bit), .r0_ready_o(r0_ready10), .r0_we_i(z_bit), .r0_addr_i(z_addr),
    .r0_wdata_i(z_data), .r0_rvalid_o(r0_rvalid10), .r0_rdata_o(r0_rdata10),
    .r1_valid_i(z_bit), .r1_ready_o(r1_ready10), .r1_we_i(z_bit), .r1_addr_i(z_addr),
    .r1_wdata_i(z_data), .r1_rvalid_o(r1_rvalid10), .r1_rdata_o(r1_rdata10),
    .fill_start_i(f10_start), .fill_data_i(f10_data),
    .fill_busy_o(busy10), .fill_done_o(done10),
    .bram_addr_o(addr10), .bram_we_o(we10), .bram_din_o(din10),
    .bram_dout_i(dout10), .dbg_state_o(dbg10)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  int            due0_q[$];
  int            due1_q[$];
  logic [DW-1:0] ref_mem [16];
  logic          model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (r0_rvalid) begin
        if (exp0_q.size() == 0) check("r0_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          check("r0_rvalid_cycle", cyc, due0_q.pop_front());
          check("r0_rdata", r0_rdata, exp0_q.pop_front());
        end
      end else if (due0_q.size() != 0 && due0_q[0] <= cyc) begin
        check("r0_rvalid_missing", 32'd0, 32'd1);
        void'(due0_q.pop_front());
        void'(exp0_q.pop_front());
      end
      if (r1_rvalid) begin
        if (exp1_q.size() == 0) check("r1_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          check("r1_rvalid_cycle", cyc, due1_q.pop_front());
          check("r1_rdata", r1_rdata, exp1_q.pop_front());
        end
      end else if (due1_q.size() != 0 && due1_q[0] <= cyc) begin
        check("r1_rvalid_missing", 32'd0, 32'd1);
        void'(due1_q.pop_front());
        void'(exp1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    fill_start = 0; fill_data = '0;
  endtask

  // One IDLE-state cycle: drive both requesters, check grant and port A, log expectations.
  task automatic step(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [1:0] g;
    @(negedge clk);
    r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
    if (v0 && v1) g = model_last ? 2'b01 : 2'b10;
    else          g = {v1, v0};
    check("r0_ready", r0_ready, g[0]);
    check("r1_ready", r1_ready, g[1]);
    if (g[0]) begin
      check("bram_we", bram_we, w0);
      check("bram_addr", bram_addr, a0);
      check("bram_din", bram_din, d0);
      if (w0) ref_mem[a0] = d0;
      else begin exp0_q.push_back(ref_mem[a0]); due0_q.push_back(cyc + 1); end
    end else if (g[1]) begin
      check("bram_we", bram_we, w1);
      check("bram_addr", bram_addr, a1);
      check("bram_din", bram_din, d1);
      if (w1) ref_mem[a1] = d1;
      else begin exp1_q.push_back(ref_mem[a1]); due1_q.push_back(cyc + 1); end
    end else begin
      check("bram_idle_port", {bram_we, bram_addr, bram_din}, 32'd0);
    end
    if (g != 2'b00) model_last = g[1];
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      r0_valid = 0; r1_valid = 0; fill_start = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    #1;
    check("rst_busy", fill_busy, 1'b0);
    check("rst_done", fill_done, 1'b0);
    check("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
    check("rst_state", dbg16, ST_IDLE);
    @(negedge clk);
    rst = 0;
    model_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; mem_init = 1;
    clear_inputs();
    z_bit = 0; z_addr = '0; z_data = '0; f10_start = 0; f10_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 0;
    do_reset();

    // write 0xA5 @3 then read it back on r0
    step(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
    step(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    idle_cycles(2);

    // both valid continuously after reset: r0, r1, r0, r1
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 4'd3, 8'h00, 1, 0, 4'd4, 8'h00);
    idle_cycles(2);

    // mixed random traffic
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    idle_cycles(2);

    // fill 0x3C with an r0 read accepted in the start cycle
    @(negedge clk);
    fill_start = 1; fill_data = 8'h3C;
    r0_valid = 1; r0_we = 0; r0_addr = 4'd3; r1_valid = 0;
    #1;
    check("fill_start_r0_ready", r0_ready, 1'b1);
    exp0_q.push_back(ref_mem[3]); due0_q.push_back(cyc + 1);
    model_last = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        fill_start = 0;
        r0_valid = 1; r0_addr = 4'd5; r1_valid = 1; r1_we = 0; r1_addr = 4'd6;
      end
      if (i == 7) begin fill_start = 1; fill_data = 8'hFF; end
      if (i == 8) fill_start = 0;
      #1;
      check("fill_busy", fill_busy, 1'b1);
      check("fill_done_low", fill_done, 1'b0);
      check("fill_state", dbg16, ST_FILL);
      check("fill_port", {bram_we, bram_addr, bram_din}, {1'b1, 4'(i), 8'h3C});
      check("fill_ready", {r1_ready, r0_ready}, 2'b00);
    end
    step(1, 0, 4'd5, 8'h00, 1, 0, 4'd6, 8'h00);
    check("fill_done_pulse", fill_done, 1'b1);
    check("fill_busy_end", fill_busy, 1'b0);
    step(1, 0, 4'd5, 8'h00, 1, 0, 4'd6, 8'h00);
    check("fill_done_once", fill_done, 1'b0);
    for (int a = 0; a < 16; a++) step(1, 0, 4'(a), 8'h00, 0, 0, 4'd0, 8'h00);
    idle_cycles(2);

    // fill 0x96, reset in fill cycle 5
    @(negedge clk);
    fill_start = 1; fill_data = 8'h96;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fill_start = 0;
      #1;
      check("abort_fill_addr", bram_addr, 4'(i));
    end
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_busy_drop", fill_busy, 1'b0);
    check("abort_no_done", fill_done, 1'b0);
    @(negedge clk);
    #1;
    check("abort_no_done_after", fill_done, 1'b0);
    rst = 0;
    model_last = 1'b1;
    for (int i = 0; i < 5; i++) ref_mem[i] = 8'h96;
    for (int a = 0; a < 16; a++) step(0, 0, 4'd0, 8'h00, 1, 0, 4'(a), 8'h00);
    idle_cycles(2);

    // 10-word fill
    @(negedge clk);
    f10_start = 1; f10_data = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f10_start = 0;
      #1;
      check("fill10_busy", busy10, 1'b1);
      check("fill10_port", {we10, addr10, din10}, {1'b1, 4'(i), 8'h77});
    end
    @(negedge clk);
    #1;
    check("fill10_busy_end", busy10, 1'b0);
    check("fill10_done", done10, 1'b1);
    @(negedge clk);
    #1;
    check("fill10_done_once", done10, 1'b0);
    for (int a = 0; a < 16; a++) check("fill10_mem", mem10[a], (a < 10) ? 8'h77 : 8'h00);

    idle_cycles(3);
    check("scoreboard_drained", exp0_q.size() + exp1_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
